// File: rtl/spc_image_sink.sv
// Receiving end of the SPC image stream: checks the header signature, captures the
// SPC700 registers and queues ARAM / DSP register bytes for a ready/ack write port.
module spc_image_sink #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_start_i,
  input  logic [7:0]  din_i,
  input  logic [16:0] din_addr_i,
  input  logic        din_valid_i,
  input  logic        load_done_i,
  output logic        wr_req_o,
  output logic        wr_sel_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  input  logic        wr_ack_i,
  output logic [15:0] cpu_pc_o,
  output logic [7:0]  cpu_a_o,
  output logic [7:0]  cpu_x_o,
  output logic [7:0]  cpu_y_o,
  output logic [7:0]  cpu_psw_o,
  output logic [7:0]  cpu_sp_o,
  output logic        regs_valid_o,
  output logic        image_ok_o,
  output logic [2:0]  err_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [16:0] LAST_ADDR  = 17'h101FF;
  localparam logic [16:0] IMAGE_SIZE = 17'h10200;

  typedef enum logic [2:0] {IDLE, RECV, DRAIN, DONE, ERR} state_t;

  typedef struct packed {
    logic        sel;
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

  state_t        state_q, state_d;
  logic [16:0]   exp_q, exp_d;
  logic          sig_bad_q, sig_bad_d;
  logic [15:0]   pc_q, pc_d;
  logic [7:0]    a_q, a_d, x_q, x_d, y_q, y_d, psw_q, psw_d, sp_q, sp_d;
  logic          regs_valid_q, regs_valid_d;
  logic [2:0]    err_q, err_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [FIFO_DEPTH];

  entry_t entry, head;
  logic   routed, push, pop, flush, full, sig_mismatch;

  function automatic logic [7:0] sig_char(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h53;
      4'd1:    return 8'h4E;
      4'd2:    return 8'h45;
      4'd3:    return 8'h53;
      4'd4:    return 8'h2D;
      4'd5:    return 8'h53;
      4'd6:    return 8'h50;
      4'd7:    return 8'h43;
      4'd8:    return 8'h37;
      4'd9:    return 8'h30;
      4'd10:   return 8'h30;
      default: return 8'h00;
    endcase
  endfunction

  // Address decode of the incoming byte into a write-port entry.
  always_comb begin
    entry      = '0;
    entry.data = din_i;
    routed     = 1'b0;
    if (din_addr_i >= 17'h00100 && din_addr_i <= 17'h100FF) begin
      routed     = 1'b1;
      entry.addr = din_addr_i[15:0] - 16'h0100;
    end else if (din_addr_i >= 17'h10100 && din_addr_i <= 17'h1017F) begin
      routed     = 1'b1;
      entry.sel  = 1'b1;
      entry.addr = {9'd0, din_addr_i[6:0]};
    end else if (din_addr_i >= 17'h101C0 && din_addr_i <= LAST_ADDR) begin
      routed     = 1'b1;
      entry.addr = {10'h3FF, din_addr_i[5:0]};
    end
    sig_mismatch = (din_addr_i <= 17'h0000A) && (din_i != sig_char(din_addr_i[3:0]));
  end

  assign full = (count_q == CW'(FIFO_DEPTH));

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    sig_bad_d    = sig_bad_q;
    pc_d         = pc_q;
    a_d          = a_q;
    x_d          = x_q;
    y_d          = y_q;
    psw_d        = psw_q;
    sp_d         = sp_q;
    regs_valid_d = regs_valid_q;
    err_d        = err_q;
    push         = 1'b0;
    flush        = 1'b0;
    pop          = (count_q != '0) && wr_ack_i;

    if (load_start_i) begin
      state_d      = RECV;
      exp_d        = '0;
      sig_bad_d    = 1'b0;
      pc_d         = '0;
      a_d          = '0;
      x_d          = '0;
      y_d          = '0;
      psw_d        = '0;
      sp_d         = '0;
      regs_valid_d = 1'b0;
      err_d        = '0;
      flush        = 1'b1;
    end else begin
      case (state_q)
        RECV: begin
          // Error causes are tested in priority order: ordering, signature, overflow, short.
          if (din_valid_i && din_addr_i != exp_q) begin
            state_d = ERR;
            err_d   = 3'd2;
            flush   = 1'b1;
          end else if (din_valid_i && din_addr_i == 17'h0000A && (sig_bad_q || sig_mismatch)) begin
            state_d = ERR;
            err_d   = 3'd1;
            flush   = 1'b1;
          end else if (din_valid_i && routed && full && !pop) begin
            state_d = ERR;
            err_d   = 3'd3;
            flush   = 1'b1;
          end else if (load_done_i && exp_q != IMAGE_SIZE) begin
            state_d = ERR;
            err_d   = 3'd4;
            flush   = 1'b1;
          end else if (din_valid_i) begin
            exp_d     = exp_q + 17'd1;
            sig_bad_d = sig_bad_q | sig_mismatch;
            push      = routed;
            case (din_addr_i)
              17'h00025: pc_d[7:0]  = din_i;
              17'h00026: pc_d[15:8] = din_i;
              17'h00027: a_d        = din_i;
              17'h00028: x_d        = din_i;
              17'h00029: y_d        = din_i;
              17'h0002A: psw_d      = din_i;
              17'h0002B: begin
                sp_d         = din_i;
                regs_valid_d = ~sig_bad_q;
              end
              default: ;
            endcase
            if (din_addr_i == LAST_ADDR) state_d = DRAIN;
          end
        end
        DRAIN: if (count_q == '0) state_d = DONE;
        default: ;
      endcase
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      exp_q        <= '0;
      sig_bad_q    <= 1'b0;
      pc_q         <= '0;
      a_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      psw_q        <= '0;
      sp_q         <= '0;
      regs_valid_q <= 1'b0;
      err_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      sig_bad_q    <= sig_bad_d;
      pc_q         <= pc_d;
      a_q          <= a_d;
      x_q          <= x_d;
      y_q          <= y_d;
      psw_q        <= psw_d;
      sp_q         <= sp_d;
      regs_valid_q <= regs_valid_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset; the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  assign head         = mem_q[rd_ptr_q];
  assign wr_req_o     = (count_q != '0);
  assign wr_sel_o     = wr_req_o & head.sel;
  assign wr_addr_o    = wr_req_o ? head.addr : 16'h0000;
  assign wr_data_o    = wr_req_o ? head.data : 8'h00;
  assign cpu_pc_o     = pc_q;
  assign cpu_a_o      = a_q;
  assign cpu_x_o      = x_q;
  assign cpu_y_o      = y_q;
  assign cpu_psw_o    = psw_q;
  assign cpu_sp_o     = sp_q;
  assign regs_valid_o = regs_valid_q;
  assign image_ok_o   = (state_q == DONE);
  assign err_o        = err_q;

endmodule

// File: doc/spc_image_sink.md
Name: spc_image_sink

Overview:
- Receiving end of the SD loader byte stream: consumes the 0x10200-byte SPC image as (byte, address, valid) triples.
- Checks the header signature and captures the SPC700 CPU registers.
- Routes the 64 KB ARAM, 128 DSP registers and the 64-byte extra-RAM tail into a shared, ready/ack memory-write port through a small FIFO.
- Sits between the SD loader and the ARAM/DSP register files; flags image completion or the error cause to the player control.

Parameters:
- FIFO_DEPTH, 4, write-FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load_start  in  1  pulse at song load start; clears all state and enters RECV.
- din  in  8  image byte.
- din_addr  in  17  image byte offset.
- din_valid  in  1  one-cycle strobe, no backpressure.
- load_done  in  1  loader completion level.
- wr_req  out  1  write pending (level).
- wr_sel  out  1  0 = ARAM, 1 = DSP register.
- wr_addr  out  16  ARAM address, or DSP index in [6:0] with upper bits 0.
- wr_data  out  8  write data.
- wr_ack  in  1  entry consumed when wr_req & wr_ack.
- cpu_pc  out  16  captured PC.
- cpu_a, cpu_x, cpu_y, cpu_psw, cpu_sp  out  8 each  captured registers.
- regs_valid  out  1  CPU registers captured and signature good.
- image_ok  out  1  full image received and all writes acked.
- err  out  3  error code: 0 none, 1 bad signature, 2 out-of-order address, 3 FIFO overflow, 4 short image.

Behaviour:
- Reset (and load_start): every output is 0; FIFO empty; expected counter exp=0; state IDLE. load_start in any state restarts.
- States:
  - IDLE: ignore din_valid. Enter RECV on load_start.
  - RECV: accept bytes.
  - DRAIN: entered after byte 0x101FF is accepted; go to DONE when the FIFO is empty.
  - DONE: image_ok=1. Hold until load_start or reset.
  - ERR: err latched nonzero; input ignored. Hold until load_start or reset.
- Ordering check in RECV: on din_valid, din_addr must equal exp, else ERR with err=2. On an accepted byte, exp increments (17-bit).
- Signature check:
  - Bytes 0x00-0x0A must equal ASCII "SNES-SPC700".
  - Any mismatch is flagged; at byte 0x0A with a mismatch, go to ERR with err=1.
- Register capture:
  - 0x25 -> pc[7:0]; 0x26 -> pc[15:8]; 0x27 -> A; 0x28 -> X; 0x29 -> Y; 0x2A -> PSW; 0x2B -> SP.
  - regs_valid rises the cycle after byte 0x2B is accepted.
- Routing (push to FIFO):
  - 0x00100-0x100FF: ARAM, address = din_addr-0x100.
  - 0x10100-0x1017F: DSP, index = din_addr[6:0].
  - 0x101C0-0x101FF: ARAM, address 0xFFC0 + din_addr[5:0]; overwrites the earlier shadow bytes.
  - All other offsets: not written.
- FIFO and write port:
  - wr_req = FIFO not empty; wr_sel, wr_addr and wr_data come from the FIFO head.
  - Head outputs are stable while wr_req & ~wr_ack.
  - Latency: a byte accepted in cycle N with the FIFO empty gives wr_req=1 in N+1.
  - Push and pop in the same cycle are legal even when full; occupancy is unchanged.
  - Push while full without a pop: ERR, err=3.
- Short image: load_done=1 while in RECV with exp != 0x10200 gives ERR, err=4. load_done in DRAIN or DONE is ignored.
- Entering ERR flushes the FIFO; wr_req is 0 from the next cycle. A wr_ack with wr_req=0 is ignored.
- Error priority when events coincide in one cycle: 2 > 1 > 3 > 4.
- err and image_ok are mutually exclusive.

Test Plan:
- Valid image, wr_ack tied 1: 0x10200 ordered bytes (ARAM byte k = k[7:0]) -> 65536+128+64 writes, ARAM 0xFFC0-0xFFFF carry the tail bytes, image_ok=1, err=0, cpu_pc equals the 0x25/0x26 bytes, regs_valid=1.
- Byte 0x03 = 'X': err=1 one cycle after offset 0x0A, no writes issued, regs_valid=0.
- Skip offset 0x200 (send 0x201 next): err=2, wr_req=0 next cycle.
- wr_ack held 0 with FIFO_DEPTH=4: the 5th routed byte gives err=3; with ack every other cycle and bytes every 2 cycles, no error.
- load_done asserted after 0x8000 bytes: err=4, image_ok=0.
- load_start mid-DRAIN, then a full valid image: state cleared, second load completes with image_ok=1.
